// File: rtl/vp_key_queue_if.sv
// vp_key_queue_if: consumer-side bus of the key queue (head entry, pop strobe, level, overflow)
interface vp_key_queue_if #(parameter int DEPTH = 8);
  logic                   rx_data_ready_o;
  logic [7:0]             rx_ascii_o;
  logic                   rx_released_o;
  logic                   rx_read_i;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overflow_o;
  modport master (output rx_data_ready_o, rx_ascii_o, rx_released_o, level_o, overflow_o, input rx_read_i);
  modport slave (input rx_data_ready_o, rx_ascii_o, rx_released_o, level_o, overflow_o, output rx_read_i);
endinterface

// File: rtl/vp_key_queue.sv
// vp_key_queue: merges PS/2 key events and numpad joystick edges into one ASCII FIFO; ports clk_sys, reset, ps2_key, joy_numpad, rx (queue bus)
module vp_key_queue #(
  parameter int DEPTH = 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [10:0]  ps2_key,
  input  logic [9:0]   joy_numpad,
  vp_key_queue_if.master rx
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          tog_q, primed_q, ps2_vld_q, ps2_vld_d, ovf_q, ovf_d, rdy_q, rdy_d;
  logic [8:0]    ps2_ent_q, ps2_ent_d, head_q, head_d, xl, joy_ent, push_ent;
  logic [9:0]    joy_q, joy_prev_q, pp_q, pp_d, pr_q, pr_d;
  logic [3:0]    sel;
  logic          full, pop, push, joy_push, unused;
  function automatic logic [8:0] xlate(input logic [7:0] sc);
    case (sc)
      8'h16: return {1'b1, 8'h31};  8'h1E: return {1'b1, 8'h32};  8'h26: return {1'b1, 8'h33};
      8'h25: return {1'b1, 8'h34};  8'h2E: return {1'b1, 8'h35};  8'h36: return {1'b1, 8'h36};
      8'h3D: return {1'b1, 8'h37};  8'h3E: return {1'b1, 8'h38};  8'h46: return {1'b1, 8'h39};
      8'h45: return {1'b1, 8'h30};
      8'h1C: return {1'b1, "a"};  8'h32: return {1'b1, "b"};  8'h21: return {1'b1, "c"};
      8'h23: return {1'b1, "d"};  8'h24: return {1'b1, "e"};  8'h2B: return {1'b1, "f"};
      8'h34: return {1'b1, "g"};  8'h33: return {1'b1, "h"};  8'h43: return {1'b1, "i"};
      8'h3B: return {1'b1, "j"};  8'h42: return {1'b1, "k"};  8'h4B: return {1'b1, "l"};
      8'h3A: return {1'b1, "m"};  8'h31: return {1'b1, "n"};  8'h44: return {1'b1, "o"};
      8'h4D: return {1'b1, "p"};  8'h15: return {1'b1, "q"};  8'h2D: return {1'b1, "r"};
      8'h1B: return {1'b1, "s"};  8'h2C: return {1'b1, "t"};  8'h3C: return {1'b1, "u"};
      8'h2A: return {1'b1, "v"};  8'h1D: return {1'b1, "w"};  8'h22: return {1'b1, "x"};
      8'h35: return {1'b1, "y"};  8'h1A: return {1'b1, "z"};
      8'h29: return {1'b1, " "};  8'h79: return {1'b1, "+"};  8'h7B: return {1'b1, "-"};
      8'h7C: return {1'b1, "*"};  8'h4A: return {1'b1, "/"};  8'h55: return {1'b1, "="};
      8'h1F: return {1'b1, 8'h11};  8'h27: return {1'b1, 8'h12};
      8'h5A: return {1'b1, 8'h0A};  8'h66: return {1'b1, 8'h08};
      default: return 9'h000;
    endcase
  endfunction
  assign unused = ps2_key[8];
  always_comb begin
    xl = xlate(ps2_key[7:0]);
    // events are staged one cycle so the push lands on the second edge after the toggle
    ps2_vld_d = primed_q && (ps2_key[10] != tog_q) && xl[8];
    ps2_ent_d = {~ps2_key[9], xl[7:0]};
    full = level_q == LW'(DEPTH);
    pop = rx.rx_read_i && rdy_q;
    sel = 4'd0;
    for (int i = 9; i >= 0; i--) if (pp_q[i] || pr_q[i]) sel = i[3:0];
    joy_ent = {~pp_q[sel], sel == 4'd9 ? 8'h30 : 8'h31 + {4'h0, sel}};
    joy_push = |(pp_q | pr_q) && !ps2_vld_q && !full;
    push = (ps2_vld_q && !full) || joy_push;
    push_ent = ps2_vld_q ? ps2_ent_q : joy_ent;
    pp_d = pp_q;
    pr_d = pr_q;
    if (joy_push && pp_q[sel]) pp_d[sel] = 1'b0;
    if (joy_push && !pp_q[sel]) pr_d[sel] = 1'b0;
    pp_d = pp_d | (joy_q & ~joy_prev_q);
    pr_d = pr_d | (~joy_q & joy_prev_q);
    ovf_d = ovf_q || (ps2_vld_q && full);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
    rdy_d = level_d != '0;
    // when the queue drains to nothing this cycle, the entry being written becomes the head
    head_d = level_d == '0 ? head_q : (push && level_q == LW'(pop)) ? push_ent : mem[rd_ptr_d];
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
      tog_q <= 1'b0;
      primed_q <= 1'b0;
      ps2_vld_q <= 1'b0;
      ps2_ent_q <= '0;
      joy_q <= '0;
      joy_prev_q <= '0;
      pp_q <= '0;
      pr_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
      head_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
      tog_q <= ps2_key[10];
      primed_q <= 1'b1;
      ps2_vld_q <= ps2_vld_d;
      ps2_ent_q <= ps2_ent_d;
      joy_q <= joy_numpad;
      // the priming edge loads both joystick stages so no edge is seen from reset values
      joy_prev_q <= primed_q ? joy_q : joy_numpad;
      pp_q <= pp_d;
      pr_q <= pr_d;
      ovf_q <= ovf_d;
      rdy_q <= rdy_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk_sys) if (push) mem[wr_ptr_q] <= push_ent;
  assign rx.rx_data_ready_o = rdy_q;
  assign rx.rx_ascii_o = head_q[7:0];
  assign rx.rx_released_o = head_q[8];
  assign rx.level_o = level_q;
  assign rx.overflow_o = ovf_q;
endmodule

// File: tb/tb_vp_key_queue.sv
// tb_vp_key_queue: directed stimulus with a queue-level reference model checked every cycle
module tb_vp_key_queue;
  localparam int DEPTH = 8;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic [9:0]  joy_numpad = '0;
  int          checks = 0;
  int          errors = 0;
  vp_key_queue_if #(.DEPTH(DEPTH)) rx ();
  vp_key_queue #(.DEPTH(DEPTH)) dut (.clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_numpad(joy_numpad), .rx(rx));
  always #5 clk_sys = ~clk_sys;
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
                                 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] misc_sc [10] = '{8'h29, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h55, 8'h1F, 8'h27, 8'h5A, 8'h66};
  logic [7:0] misc_ch [10] = '{8'h20, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D, 8'h11, 8'h12, 8'h0A, 8'h08};
  function automatic int tb_map(input logic [7:0] sc);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) return 8'h61 + i;
    for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) return i == 9 ? 8'h30 : 8'h31 + i;
    for (int i = 0; i < 10; i++) if (misc_sc[i] == sc) return int'(misc_ch[i]);
    return -1;
  endfunction
  function automatic logic [7:0] digit(input int i);
    return i == 9 ? 8'h30 : 8'(8'h31 + i);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [8:0] mq [$];
  bit         m_ovf = 0, m_primed = 0, st_v = 0, ptog = 0;
  logic [8:0] st_e = '0;
  logic [9:0] j1 = '0, j2 = '0, pend_p = '0, pend_r = '0;
  always @(posedge clk_sys or posedge reset) begin
    bit full, pop, psh;
    logic [8:0] pe;
    int code;
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_primed = 0;
      st_v = 0;
      pend_p = '0;
      pend_r = '0;
    end else if (!m_primed) begin
      m_primed = 1;
      ptog = ps2_key[10];
      j1 = joy_numpad;
      j2 = joy_numpad;
    end else begin
      full = mq.size() == DEPTH;
      pop = rx.rx_read_i && mq.size() != 0;
      psh = 0;
      pe = '0;
      if (st_v) begin
        if (full) m_ovf = 1;
        else begin psh = 1; pe = st_e; end
      end else if (!full) begin
        for (int i = 0; i < 10 && !psh; i++) begin
          if (pend_p[i]) begin psh = 1; pe = {1'b0, digit(i)}; pend_p[i] = 0; end
          else if (pend_r[i]) begin psh = 1; pe = {1'b1, digit(i)}; pend_r[i] = 0; end
        end
      end
      if (pop) void'(mq.pop_front());
      if (psh) mq.push_back(pe);
      pend_p = pend_p | (j1 & ~j2);
      pend_r = pend_r | (~j1 & j2);
      j2 = j1;
      j1 = joy_numpad;
      code = tb_map(ps2_key[7:0]);
      st_v = ps2_key[10] != ptog && code >= 0;
      st_e = {~ps2_key[9], 8'(code)};
      ptog = ps2_key[10];
    end
  end
  always @(negedge clk_sys) begin
    if (!reset) begin
      chk("ready", int'(rx.rx_data_ready_o), int'(mq.size() != 0));
      chk("level", int'(rx.level_o), mq.size());
      chk("overflow", int'(rx.overflow_o), int'(m_ovf));
      if (mq.size() != 0) begin
        chk("ascii", int'(rx.rx_ascii_o), int'(mq[0][7:0]));
        chk("released", int'(rx.rx_released_o), int'(mq[0][8]));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic ps2(input logic [7:0] sc, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, sc};
    tick(1);
  endtask
  task automatic drain();
    int n = 0;
    rx.rx_read_i = 1'b1;
    while (rx.level_o != 0 && n < 40) begin tick(1); n++; end
    rx.rx_read_i = 1'b0;
    chk("drain_done", int'(rx.level_o), 0);
    tick(1);
  endtask
  initial begin
    rx.rx_read_i = 1'b0;
    tick(3);
    chk("rst_ready", int'(rx.rx_data_ready_o), 0);
    chk("rst_level", int'(rx.level_o), 0);
    chk("rst_ovf", int'(rx.overflow_o), 0);
    chk("rst_ascii", int'(rx.rx_ascii_o), 0);
    chk("rst_released", int'(rx.rx_released_o), 0);
    reset = 1'b0;
    tick(4);
    chk("prime_no_entry", int'(rx.level_o), 0);
    ps2(8'h1C, 1'b1);
    chk("ps2_lat1_ready", int'(rx.rx_data_ready_o), 0);
    tick(1);
    chk("ps2_lat2_ready", int'(rx.rx_data_ready_o), 1);
    chk("ps2_a_ascii", int'(rx.rx_ascii_o), 8'h61);
    chk("ps2_a_released", int'(rx.rx_released_o), 0);
    rx.rx_read_i = 1'b1;
    tick(1);
    rx.rx_read_i = 1'b0;
    chk("pop_ready", int'(rx.rx_data_ready_o), 0);
    chk("pop_level", int'(rx.level_o), 0);
    joy_numpad = 10'h005;
    tick(2);
    chk("joy_lat2_ready", int'(rx.rx_data_ready_o), 0);
    tick(1);
    chk("joy_lat3_ready", int'(rx.rx_data_ready_o), 1);
    chk("joy_1_press", int'(rx.rx_ascii_o), 8'h31);
    tick(1);
    chk("joy_two_level", int'(rx.level_o), 2);
    rx.rx_read_i = 1'b1;
    tick(1);
    rx.rx_read_i = 1'b0;
    chk("joy_3_press", int'(rx.rx_ascii_o), 8'h33);
    chk("joy_3_press_rel", int'(rx.rx_released_o), 0);
    drain();
    joy_numpad = 10'h000;
    tick(3);
    chk("joy_1_release", int'(rx.rx_ascii_o), 8'h31);
    chk("joy_1_release_rel", int'(rx.rx_released_o), 1);
    tick(1);
    drain();
    ps2(8'h76, 1'b1);
    tick(3);
    chk("unmapped_level", int'(rx.level_o), 0);
    chk("unmapped_ovf", int'(rx.overflow_o), 0);
    ps2(8'h5A, 1'b0);
    tick(1);
    chk("enter_rel_ascii", int'(rx.rx_ascii_o), 8'h0A);
    chk("enter_rel_flag", int'(rx.rx_released_o), 1);
    drain();
    joy_numpad = 10'h010;
    ps2(8'h29, 1'b1);
    tick(1);
    chk("same_cycle_first", int'(rx.rx_ascii_o), 8'h20);
    tick(1);
    chk("same_cycle_level", int'(rx.level_o), 2);
    rx.rx_read_i = 1'b1;
    tick(1);
    rx.rx_read_i = 1'b0;
    chk("same_cycle_second", int'(rx.rx_ascii_o), 8'h35);
    joy_numpad = 10'h000;
    tick(4);
    drain();
    for (int i = 0; i < 9; i++) ps2(letter_sc[i], 1'b1);
    tick(2);
    chk("full_level", int'(rx.level_o), 8);
    chk("full_ovf", int'(rx.overflow_o), 1);
    rx.rx_read_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_order", int'(rx.rx_ascii_o), 8'h61 + i);
      tick(1);
    end
    rx.rx_read_i = 1'b0;
    chk("ninth_absent", int'(rx.level_o), 0);
    for (int i = 0; i < 8; i++) ps2(letter_sc[10 + i], 1'b1);
    tick(2);
    chk("refill_level", int'(rx.level_o), 8);
    joy_numpad = 10'h001;
    tick(2);
    rx.rx_read_i = 1'b1;
    tick(1);
    rx.rx_read_i = 1'b0;
    chk("full_pop_only", int'(rx.level_o), 7);
    chk("full_pop_head", int'(rx.rx_ascii_o), 8'h6C);
    tick(1);
    chk("full_joy_late", int'(rx.level_o), 8);
    joy_numpad = 10'h000;
    drain();
    tick(4);
    drain();
    rx.rx_read_i = 1'b1;
    tick(2);
    rx.rx_read_i = 1'b0;
    chk("empty_read_level", int'(rx.level_o), 0);
    ps2(letter_sc[3], 1'b1);
    ps2(letter_sc[4], 1'b1);
    tick(2);
    chk("pre_reset_level", int'(rx.level_o), 2);
    #2 reset = 1'b1;
    #1 chk("async_ready", int'(rx.rx_data_ready_o), 0);
    chk("async_level", int'(rx.level_o), 0);
    chk("async_ovf", int'(rx.overflow_o), 0);
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("post_reset_level", int'(rx.level_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vp_key_queue.md
VP_KEY_QUEUE -- requirements
Module: vp_key_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, 4..16.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ps2_key  input  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-005 SHALL have port joy_numpad  input  10  level, active-high; bit0..bit8 = "1".."9", bit9 = "0".
REQ-006 SHALL have port rx_data_ready_o  output  1  head entry valid.
REQ-007 SHALL have port rx_ascii_o  output  8  head entry ASCII code.
REQ-008 SHALL have port rx_released_o  output  1  head entry is a key release.
REQ-009 SHALL have port rx_read_i  input  1  consumer acknowledge; pops the head entry.
REQ-010 SHALL have port level_o  output  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a PS/2 event was dropped.

Function
REQ-012 SHALL detect a PS/2 event when ps2_key[10] differs from its value registered on the previous edge.
REQ-013 SHALL translate ps2_key[7:0] as follows, ignoring ps2_key[8]:
- digits 16,1E,26,25,2E,36,3D,3E,46,45 -> "1".."9","0".
- letters 1C..1A -> "a".."z" (standard set-2 map).
- 29 -> " "; 79 -> "+"; 7B -> "-"; 7C -> "*"; 4A -> "/"; 55 -> "=".
- 1F -> 0x11; 27 -> 0x12; 5A -> 0x0A; 66 -> 0x08.
REQ-014 SHALL discard events with unmapped scancodes without a push or an overflow.
REQ-015 SHALL form each entry as {released = ~ps2_key[9], ascii}, 9 bits.
REQ-016 SHALL register joy_numpad each cycle; a 0->1 bit edge sets that bit's press-pending flag and a 1->0 edge sets its release-pending flag.
REQ-017 SHALL coalesce a repeat edge of the same kind into the existing pending flag.
REQ-018 SHALL, in each cycle with no PS/2 push, service the lowest-index bit with any pending flag: press before release; push the digit with released=0 or 1; clear that flag on the same edge.
REQ-019 SHALL give a PS/2 push priority over a joystick push in the same cycle; joystick flags stay pending.
REQ-020 SHALL allow at most one push per cycle.
REQ-021 SHALL block all pushes when level_o == DEPTH, even when rx_read_i is asserted in the same cycle.
REQ-022 SHALL, when full, drop the PS/2 event and set overflow_o; joystick flags are retained and never dropped.
REQ-023 SHALL drive rx_data_ready_o = (level_o != 0), registered.
REQ-024 SHALL hold rx_ascii_o and rx_released_o stable while ready until popped.
REQ-025 SHALL pop on a rising edge where rx_read_i && rx_data_ready_o; the next entry appears the following cycle.
REQ-026 SHALL ignore rx_read_i when the queue is empty.
REQ-027 SHALL leave level_o unchanged on a simultaneous push and pop when not full; read and write pointers wrap modulo DEPTH.
REQ-028 SHALL deliver, with the queue empty:
- PS/2 event: rx_data_ready_o high 2 edges after ps2_key[10] changes.
- joystick edge: rx_data_ready_o high 3 edges after the joy_numpad change.
REQ-029 SHALL preserve FIFO order for all entries.

Reset
REQ-030 SHALL, while reset is asserted, clear to 0: pointers, level_o, pending flags, overflow_o, rx_data_ready_o, rx_ascii_o, rx_released_o.
REQ-031 SHALL, on the first edge after reset deasserts, capture ps2_key[10] and joy_numpad without generating events (priming cycle).
REQ-032 SHALL discard all queued and pending events on a reset asserted mid-operation; rx_data_ready_o falls asynchronously.
REQ-033 SHALL clear overflow_o only by reset.

Verification
REQ-034 SHALL cover: toggle flip, scancode 0x1C, pressed=1 -> after 2 edges ready=1, ascii=0x61, released=0; rx_read_i one cycle -> ready=0, level=0.
REQ-035 SHALL cover: joy_numpad 0->0x005 -> entries "1" press then "3" press on consecutive cycles; joy_numpad ->0 -> "1" release then "3" release.
REQ-036 SHALL cover: 9 mapped PS/2 events, no reads, DEPTH=8 -> level=8, overflow=1; pop 8 -> first 8 in order, 9th absent.
REQ-037 SHALL cover: PS/2 event and joystick edge in the same cycle -> PS/2 entry first, digit entry on the next cycle.
REQ-038 SHALL cover: scancode 0x76 (unmapped) -> no entry, overflow=0; ps2_key[10]=1 held through reset release -> no spurious entry.
REQ-039 SHALL cover: queue full with rx_read_i and a joystick edge in the same cycle -> pop only; digit pushed on the next cycle, level returns to 8.
